// File: rtl/rxdata_pkt_fifo.sv
`default_nettype none
// rxdata_pkt_fifo: RX packet FIFO. Frames become readable only when committed at end-of-frame,
// bad or overflowing frames are rewound away, and the read port is first-word-fall-through. Rev 1.0
module rxdata_pkt_fifo #(
  parameter int WIDTH     = 256,
  parameter int DEPTH     = 1024,
  parameter int PTR       = 10,
  parameter int AFULL_THR = 960,
  parameter int PKT_MODE  = 1
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wren,
  input  logic [WIDTH-1:0] datain,
  input  logic             wreop,
  input  logic             wrbad,
  output logic             wrfull,
  output logic             wrafull,
  output logic [PTR:0]     wrusedw,
  input  logic             rden,
  output logic [WIDTH-1:0] dataout,
  output logic             dataout_eop,
  output logic             rdempty,
  output logic [PTR:0]     rdusedw,
  output logic [15:0]      drop_cnt,
  output logic             dbg
);

  localparam logic [PTR:0] AFULL_W = (PTR+1)'(AFULL_THR);
  localparam logic [PTR:0] ONE     = (PTR+1)'(1);

  logic [WIDTH:0] mem [DEPTH];

  logic [PTR:0] wr_ptr, cmt_ptr, rd_ptr, cmt_d;
  logic [PTR:0] wr_ptr_nxt, cmt_ptr_nxt, rd_ptr_nxt;
  logic [PTR:0] wr_used_nxt, rd_used_nxt;
  logic         dropping, dropping_nxt;
  logic         accept, pop, drop_frame, rewind;

  always_comb begin
    pop          = rden && !rdempty;
    accept       = wren && !wrfull && !dropping;
    // In packet mode a write that finds the buffer full poisons the rest of its frame.
    drop_frame   = (PKT_MODE != 0) && wren && (dropping || wrfull);
    rewind       = (PKT_MODE != 0) && wren && wreop && (drop_frame || wrbad);

    wr_ptr_nxt   = wr_ptr;
    cmt_ptr_nxt  = cmt_ptr;
    dropping_nxt = dropping;
    rd_ptr_nxt   = pop ? rd_ptr + ONE : rd_ptr;

    if (rewind) begin
      wr_ptr_nxt   = cmt_ptr;
      dropping_nxt = 1'b0;
    end else if (drop_frame) begin
      dropping_nxt = 1'b1;
    end else if (accept) begin
      wr_ptr_nxt = wr_ptr + ONE;
      if (PKT_MODE == 0 || wreop) begin
        cmt_ptr_nxt = wr_ptr + ONE;
      end
    end

    wr_used_nxt = wr_ptr_nxt - rd_ptr_nxt;
    rd_used_nxt = cmt_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[PTR-1:0]] <= {wreop, datain};
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr      <= '0;
      cmt_ptr     <= '0;
      rd_ptr      <= '0;
      cmt_d       <= '0;
      dropping    <= 1'b0;
      wrusedw     <= '0;
      wrfull      <= 1'b0;
      wrafull     <= 1'b0;
      rdusedw     <= '0;
      rdempty     <= 1'b1;
      dataout     <= '0;
      dataout_eop <= 1'b0;
      drop_cnt    <= '0;
      dbg         <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      cmt_ptr  <= cmt_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      cmt_d    <= cmt_ptr;
      dropping <= dropping_nxt;

      wrusedw <= wr_used_nxt;
      wrfull  <= (wr_ptr_nxt[PTR] != rd_ptr_nxt[PTR]) &&
                 (wr_ptr_nxt[PTR-1:0] == rd_ptr_nxt[PTR-1:0]);
      wrafull <= (wr_used_nxt >= AFULL_W);
      rdusedw <= rd_used_nxt;

      // Prefetch: the RAM output register is the head word, so a pop addresses rd_ptr+1.
      {dataout_eop, dataout} <= mem[rd_ptr_nxt[PTR-1:0]];

      // Leaving empty waits on the delayed commit pointer so the first word has had a
      // full cycle in the RAM; while non-empty every committed word is already settled.
      rdempty <= rdempty ? (cmt_d == rd_ptr_nxt) : (cmt_ptr == rd_ptr_nxt);

      if (wren && wrfull) begin
        dbg <= 1'b1;
      end
      if (rewind && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rxdata_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_rxdata_pkt_fifo
// Description : Directed bench for rxdata_pkt_fifo, one packet-mode and one
//               plain-FIFO instance.
// Revision    : 1.1
// ============================================================================
module tb_rxdata_pkt_fifo;

    localparam int W = 16;
    localparam int P = 4;
    localparam int D = 16;

    logic clk    = 1'b0;
    logic reset_ = 1'b1;
    always #5 clk = ~clk;

    logic         a_wren = 1'b0, a_wreop = 1'b0, a_wrbad = 1'b0, a_rden = 1'b0;
    logic [W-1:0] a_datain = '0;
    logic         a_wrfull, a_wrafull, a_rdempty, a_dataout_eop, a_dbg;
    logic [P:0]   a_wrusedw, a_rdusedw;
    logic [W-1:0] a_dataout;
    logic [15:0]  a_drop_cnt;

    logic         b_wren = 1'b0, b_wreop = 1'b0, b_wrbad = 1'b0, b_rden = 1'b0;
    logic [W-1:0] b_datain = '0;
    logic         b_wrfull, b_wrafull, b_rdempty, b_dataout_eop, b_dbg;
    logic [P:0]   b_wrusedw, b_rdusedw;
    logic [W-1:0] b_dataout;
    logic [15:0]  b_drop_cnt;

    int tests = 0;
    int fails = 0;
    int wi, ri, maxu;

    rxdata_pkt_fifo #(.WIDTH(W), .DEPTH(D), .PTR(P), .AFULL_THR(12), .PKT_MODE(1)) u_pkt (
        .clk(clk), .reset_(reset_), .wren(a_wren), .datain(a_datain), .wreop(a_wreop),
        .wrbad(a_wrbad), .wrfull(a_wrfull), .wrafull(a_wrafull), .wrusedw(a_wrusedw),
        .rden(a_rden), .dataout(a_dataout), .dataout_eop(a_dataout_eop), .rdempty(a_rdempty),
        .rdusedw(a_rdusedw), .drop_cnt(a_drop_cnt), .dbg(a_dbg)
    );

    rxdata_pkt_fifo #(.WIDTH(W), .DEPTH(D), .PTR(P), .AFULL_THR(12), .PKT_MODE(0)) u_plain (
        .clk(clk), .reset_(reset_), .wren(b_wren), .datain(b_datain), .wreop(b_wreop),
        .wrbad(b_wrbad), .wrfull(b_wrfull), .wrafull(b_wrafull), .wrusedw(b_wrusedw),
        .rden(b_rden), .dataout(b_dataout), .dataout_eop(b_dataout_eop), .rdempty(b_rdempty),
        .rdusedw(b_rdusedw), .drop_cnt(b_drop_cnt), .dbg(b_dbg)
    );

    task automatic check(input string tag, input logic ok);
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset_ = 1'b0;
        step();
        step();
        check("rst_wrfull", a_wrfull === 1'b0);
        check("rst_wrafull", a_wrafull === 1'b0);
        check("rst_wrusedw", a_wrusedw === (P+1)'(0));
        check("rst_rdempty", a_rdempty === 1'b1);
        check("rst_rdusedw", a_rdusedw === (P+1)'(0));
        check("rst_dataout", a_dataout === W'(0));
        check("rst_eop", a_dataout_eop === 1'b0);
        check("rst_drop_cnt", a_drop_cnt === 16'd0);
        check("rst_dbg", a_dbg === 1'b0);
        check("rst_b_rdempty", b_rdempty === 1'b1);
        reset_ = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            a_wren = 1'b1; a_datain = W'(16'hA000 + i); a_wreop = (i == 3);
            step();
            check("t1_wrusedw", a_wrusedw === (P+1)'(i + 1));
            check("t1_rdempty_hold", a_rdempty === 1'b1);
        end
        a_wren = 1'b0; a_wreop = 1'b0;
        step();
        check("t1_rdempty_e1", a_rdempty === 1'b1);
        step();
        check("t1_rdempty_e2", a_rdempty === 1'b0);
        check("t1_rdusedw", a_rdusedw === (P+1)'(4));
        for (int i = 0; i < 4; i++) begin
            check("t1_nonempty", a_rdempty === 1'b0);
            check("t1_data", a_dataout === W'(16'hA000 + i));
            check("t1_eop", a_dataout_eop === (i == 3));
            a_rden = 1'b1;
            step();
        end
        a_rden = 1'b0;
        check("t1_empty_after", a_rdempty === 1'b1);
        check("t1_rdusedw_after", a_rdusedw === (P+1)'(0));

        for (int i = 0; i < 3; i++) begin
            a_wren = 1'b1; a_datain = W'(16'hB000 + i); a_wreop = (i == 2); a_wrbad = (i == 2);
            step();
        end
        check("t2_wrusedw_rewind", a_wrusedw === (P+1)'(0));
        check("t2_drop_cnt", a_drop_cnt === 16'd1);
        check("t2_rdempty", a_rdempty === 1'b1);
        a_wrbad = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_wren = 1'b1; a_datain = W'(16'hC000 + i); a_wreop = (i == 1);
            step();
        end
        a_wren = 1'b0; a_wreop = 1'b0;
        step();
        step();
        check("t2_rdusedw", a_rdusedw === (P+1)'(2));
        for (int i = 0; i < 2; i++) begin
            check("t2_nonempty", a_rdempty === 1'b0);
            check("t2_data", a_dataout === W'(16'hC000 + i));
            check("t2_eop", a_dataout_eop === (i == 1));
            a_rden = 1'b1;
            step();
        end
        a_rden = 1'b0;
        check("t2_empty_after", a_rdempty === 1'b1);

        for (int i = 0; i < 10; i++) begin
            a_wren = 1'b1; a_datain = W'(16'hE000 + i); a_wreop = (i == 9);
            step();
        end
        check("t3_used10", a_wrusedw === (P+1)'(10));
        for (int i = 0; i < 8; i++) begin
            a_wren = 1'b1; a_datain = W'(16'hF000 + i); a_wreop = (i == 7);
            step();
            if (i == 0) check("t3_afull_11", a_wrafull === 1'b0);
            if (i == 1) check("t3_afull_12", a_wrafull === 1'b1);
            if (i == 4) check("t3_notfull_15", a_wrfull === 1'b0);
            if (i == 5) begin
                check("t3_full_16", a_wrfull === 1'b1);
                check("t3_dbg_before", a_dbg === 1'b0);
            end
            if (i == 6) check("t3_dbg_set", a_dbg === 1'b1);
        end
        a_wren = 1'b0; a_wreop = 1'b0;
        check("t3_wrusedw", a_wrusedw === (P+1)'(10));
        check("t3_rdusedw", a_rdusedw === (P+1)'(10));
        check("t3_drop_cnt", a_drop_cnt === 16'd2);
        step();
        check("t3_wrfull_clear", a_wrfull === 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("t3_data", a_dataout === W'(16'hE000 + i));
            check("t3_eop", a_dataout_eop === (i == 9));
            a_rden = 1'b1;
            step();
        end
        a_rden = 1'b0;
        check("t3_empty_after", a_rdempty === 1'b1);

        wi = 0; ri = 0; maxu = 0;
        for (int c = 0; c < 400 && ri < 120; c++) begin
            a_wren   = (wi < 120);
            a_datain = W'(16'h4000 + wi);
            a_wreop  = (wi % 3 == 2);
            a_rden   = !a_rdempty && (ri < 120);
            if (a_rden) begin
                check("t4_data", a_dataout === W'(16'h4000 + ri));
                check("t4_eop", a_dataout_eop === (ri % 3 == 2));
                ri++;
            end
            step();
            if (wi < 120) wi++;
            if (int'(a_wrusedw) > maxu) maxu = int'(a_wrusedw);
        end
        a_wren = 1'b0; a_wreop = 1'b0; a_rden = 1'b0;
        check("t4_all_read", ri == 120);
        check("t4_no_drop", a_drop_cnt === 16'd2);
        check("t4_max_used", maxu <= 16);
        step();
        check("t4_empty", a_rdempty === 1'b1);
        check("t4_wrusedw", a_wrusedw === (P+1)'(0));

        b_wren = 1'b1; b_datain = 16'h5000;
        step();
        b_wren = 1'b0;
        check("t5_wrusedw1", b_wrusedw === (P+1)'(1));
        check("t5_rdempty_e0", b_rdempty === 1'b1);
        step();
        check("t5_rdempty_e1", b_rdempty === 1'b1);
        step();
        check("t5_rdempty_e2", b_rdempty === 1'b0);
        check("t5_data0", b_dataout === 16'h5000);
        for (int i = 1; i < 16; i++) begin
            b_wren = 1'b1; b_datain = W'(16'h5000 + i);
            step();
        end
        check("t5_full", b_wrfull === 1'b1);
        check("t5_afull", b_wrafull === 1'b1);
        check("t5_used16", b_wrusedw === (P+1)'(16));
        check("t5_dbg_before", b_dbg === 1'b0);
        b_datain = 16'h5FFF;
        step();
        b_wren = 1'b0;
        check("t5_used_after_drop", b_wrusedw === (P+1)'(16));
        check("t5_rdusedw", b_rdusedw === (P+1)'(16));
        check("t5_dbg", b_dbg === 1'b1);
        check("t5_drop_cnt", b_drop_cnt === 16'd0);
        for (int i = 0; i < 16; i++) begin
            check("t5_data", b_dataout === W'(16'h5000 + i));
            b_rden = 1'b1;
            step();
        end
        b_rden = 1'b0;
        check("t5_empty_after", b_rdempty === 1'b1);

        for (int i = 0; i < 5; i++) begin
            a_wren = 1'b1; a_datain = W'(16'h6000 + i); a_wreop = (i == 2);
            step();
        end
        a_wren = 1'b0; a_wreop = 1'b0;
        check("t6_nonempty", a_rdempty === 1'b0);
        for (int i = 0; i < 2; i++) begin
            check("t6_data", a_dataout === W'(16'h6000 + i));
            a_rden = 1'b1;
            step();
        end
        a_rden = 1'b0;
        check("t6_used_pre", a_wrusedw === (P+1)'(3));
        reset_ = 1'b0;
        #1;
        check("t6_rst_wrusedw", a_wrusedw === (P+1)'(0));
        check("t6_rst_rdusedw", a_rdusedw === (P+1)'(0));
        check("t6_rst_rdempty", a_rdempty === 1'b1);
        check("t6_rst_dataout", a_dataout === W'(0));
        check("t6_rst_eop", a_dataout_eop === 1'b0);
        check("t6_rst_drop_cnt", a_drop_cnt === 16'd0);
        check("t6_rst_dbg", a_dbg === 1'b0);
        check("t6_rst_b_dbg", b_dbg === 1'b0);
        check("t6_rst_wrfull", a_wrfull === 1'b0);
        step();
        reset_ = 1'b1;
        step();
        a_wren = 1'b1; a_datain = 16'h7777; a_wreop = 1'b1;
        step();
        a_wren = 1'b0; a_wreop = 1'b0;
        step();
        check("t6_post_e1", a_rdempty === 1'b1);
        step();
        check("t6_post_e2", a_rdempty === 1'b0);
        check("t6_post_data", a_dataout === 16'h7777);
        check("t6_post_eop", a_dataout_eop === 1'b1);
        a_rden = 1'b1;
        step();
        a_rden = 1'b0;
        check("t6_post_empty", a_rdempty === 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
